i2c_target_regfile: RTL and testbench
=====================================

// Module: i2c_target_regfile
// PURPOSE
//  I2C target (responder) with a small 8-bit register file, for the far end of the SoC's I2C master.
//  Lets Nios software read/write fabric control registers over the shared I2C_SDA/I2C_SCL bus.
//  Pins are open-drain, as in the top level: pin = oe ? 0 : Z.
//  No clock stretching; standard/fast mode (SCL <= 400 kHz) at 50 MHz.
// PARAMETERS
//  TARGET_ADDR  7'h2A  7-bit bus address this block answers to
//  NUM_REGS     16     register count; pointer width PW = clog2(NUM_REGS)
//  FILTER_LEN   4      clk cycles a synced SCL/SDA level must be stable to be accepted
//  HOLD_CYC     8      clk cycles after filtered SCL fall before SDA output may change
// PORTS
//  clk        in   1   system clock (50 MHz)
//  reset_n    in   1   asynchronous active-low reset
//  sda_in     in   1   raw SDA pin level
//  scl_in     in   1   raw SCL pin level
//  sda_oe     out  1   1 = pull SDA low
//  scl_oe     out  1   tied 0 (no stretching)
//  host_addr  in   PW  fabric read index into register file
//  host_rdata out  8   regs[host_addr], combinational
//  wr_strobe  out  1   1-cycle pulse when an I2C data byte is committed
//  wr_index   out  PW  register written (valid with wr_strobe)
//  wr_data    out  8   byte written (valid with wr_strobe)
//  busy       out  1   1 from accepted START to STOP
// BEHAVIOUR
//  Reset (async, reset_n=0): all outputs 0, regs = 0, pointer = 0, state IDLE; filters preset to 1 (bus idle).
//  Input path:
//   - 2-FF synchronizer, then FILTER_LEN stability filter per line.
//   - Events are computed on filtered levels only.
//  START: SDA 1->0 while SCL=1. Accepted in any state (repeated start); bit count cleared, state ADDR.
//  STOP: SDA 0->1 while SCL=1. State -> IDLE, busy=0, sda_oe released same cycle.
//  Bit timing:
//   - SDA is sampled on filtered SCL rise, MSB first.
//   - sda_oe changes only HOLD_CYC cycles after filtered SCL fall.
//  States:
//   - IDLE: sda_oe = 0.
//   - ADDR: shift 8 bits.
//     - addr[7:1] == TARGET_ADDR -> ADDR_ACK.
//     - Otherwise -> IGNORE: sda_oe = 0 until next START/STOP.
//   - ADDR_ACK: drive 0 for the 9th bit.
//     - R/W=0 -> PTR.
//     - R/W=1 -> RDATA, loading regs[ptr].
//   - PTR: 8 bits. ptr <= byte mod NUM_REGS; ACK (PTR_ACK) -> WDATA.
//   - WDATA: 8 bits, then WDATA_ACK drives ACK.
//     - On the 8th SCL rise: regs[ptr] <= byte, wr_strobe=1 for 1 cycle, ptr <= ptr+1.
//   - RDATA: drive the shift MSB first; sda_oe = ~bit. Then RDATA_ACK releases SDA and samples master ACK on 9th SCL rise.
//     - ACK (0): ptr+1, load next byte -> RDATA.
//     - NACK (1): -> IGNORE.
//  Pointer wraps NUM_REGS-1 -> 0 on both read and write auto-increment.
//  Simultaneous: fabric host_addr read never blocks an I2C write; host_rdata shows new value the cycle after wr_strobe.
//  START/STOP mid-byte: partial byte discarded, no wr_strobe, regs unchanged.
//  Reset mid-transfer: sda_oe released immediately (async).
//  busy=1 only for addressed transfers; cleared on STOP and on address mismatch.
// TESTING
//  1. Write: S,0x54,0x03,0xA5,P
//     -> ACK on 3 bytes; wr_strobe once, wr_index=3, wr_data=A5; regs[3]=A5.
//  2. Burst write from ptr 15 (NUM_REGS=16): S,0x54,0x0F,0x11,0x22,P
//     -> regs[15]=11, regs[0]=22 (wrap).
//  3. Read: S,0x54,0x03,Sr,0x55, then master ACK, ACK, NACK, P
//     -> bytes A5, regs[4], regs[5]; SDA released after NACK.
//  4. Wrong address: S,0x56,0x01,P
//     -> sda_oe never 1, no wr_strobe, busy stays 0.
//  5. STOP after 4 data bits of a write byte -> no wr_strobe, regs unchanged; next transfer works.
//  6. 2-cycle SDA glitch while SCL high (FILTER_LEN=4) -> no START/STOP detected; reset_n low mid-read -> sda_oe=0 same cycle.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target with a small byte-wide register file. The bus side writes and reads the registers through
// an auto-incrementing pointer, and the fabric reads the same registers through host_addr/host_rdata.
module i2c_target_regfile #(
  parameter logic [6:0] TARGET_ADDR = 7'h2A,
  parameter int         NUM_REGS    = 16,
  parameter int         FILTER_LEN  = 4,
  parameter int         HOLD_CYC    = 8,
  parameter int         PW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sda_in,
  input  logic          scl_in,
  output logic          sda_oe,
  output logic          scl_oe,
  input  logic [PW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_index,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic [3:0]    dbg_state
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Index 0 carries SCL and index 1 carries SDA through the synchronizer and the glitch filter.
  logic [1:0]    r_meta;
  logic [1:0]    r_sync;
  logic [1:0]    r_filt;
  logic [1:0]    r_filt_d;
  logic [FW-1:0] r_fcnt [2];

  logic          r_rw;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic [PW-1:0] r_ptr;
  logic [7:0]    r_regs [NUM_REGS];
  logic [HW-1:0] r_hold_cnt;

  logic          w_scl_f;
  logic          w_sda_f;
  logic          w_scl_rise;
  logic          w_scl_fall;
  logic          w_start;
  logic          w_stop;
  logic          w_last_bit;
  logic          w_addr_match;
  logic          w_hold_tick;
  logic [7:0]    w_byte;
  logic [PW-1:0] w_ptr_mod;
  logic [PW-1:0] w_ptr_inc;
  logic          w_oe_want;
  logic          w_addr_hit;
  logic          w_addr_miss;
  logic          w_ptr_load;
  logic          w_commit;
  logic          w_rd_first;
  logic          w_rd_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta   <= 2'b11;
      r_sync   <= 2'b11;
      r_filt   <= 2'b11;
      r_filt_d <= 2'b11;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_meta   <= {sda_in, scl_in};
      r_sync   <= r_meta;
      r_filt_d <= r_filt;
      // A new level is taken only after FILTER_LEN consecutive cycles of disagreement with the old one.
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_scl_f      = r_filt[0];
  assign w_sda_f      = r_filt[1];
  assign w_scl_rise   = w_scl_f & ~r_filt_d[0];
  assign w_scl_fall   = ~w_scl_f & r_filt_d[0];
  assign w_start      = w_scl_f & r_filt_d[0] & r_filt_d[1] & ~w_sda_f;
  assign w_stop       = w_scl_f & r_filt_d[0] & ~r_filt_d[1] & w_sda_f;
  assign w_last_bit   = (r_bit_cnt == 3'd7);
  assign w_byte       = {r_shift[6:0], w_sda_f};
  assign w_addr_match = (r_shift[6:0] == TARGET_ADDR);
  assign w_ptr_mod    = PW'({24'd0, w_byte} % NUM_REGS);
  assign w_ptr_inc    = (r_ptr == PW'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;
  assign w_hold_tick  = (r_hold_cnt == HW'(1));

  // SDA may only move HOLD_CYC cycles after SCL falls, so every data/ACK bit is held past the master's edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_cnt <= '0;
    end else if (w_scl_fall) begin
      r_hold_cnt <= HW'(HOLD_CYC);
    end else if (r_hold_cnt != '0) begin
      r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
    end else if (w_scl_rise) begin
      case (r_state)
        S_ADDR:      if (w_last_bit) w_state_nxt = w_addr_match ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:  w_state_nxt = r_rw ? S_RDATA : S_PTR;
        S_PTR:       if (w_last_bit) w_state_nxt = S_PTR_ACK;
        S_PTR_ACK:   w_state_nxt = S_WDATA;
        S_WDATA:     if (w_last_bit) w_state_nxt = S_WDATA_ACK;
        S_WDATA_ACK: w_state_nxt = S_WDATA;
        S_RDATA:     if (w_last_bit) w_state_nxt = S_RDATA_ACK;
        S_RDATA_ACK: w_state_nxt = w_sda_f ? S_IGNORE : S_RDATA;
        default:     w_state_nxt = r_state;
      endcase
    end
  end

  // START and STOP need SCL high in both cycles, so they never coincide with an SCL rise.
  always_comb begin
    w_oe_want   = 1'b0;
    w_addr_hit  = 1'b0;
    w_addr_miss = 1'b0;
    w_ptr_load  = 1'b0;
    w_commit    = 1'b0;
    w_rd_first  = 1'b0;
    w_rd_next   = 1'b0;
    case (r_state)
      S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: w_oe_want = 1'b1;
      S_RDATA:                            w_oe_want = ~r_shift[7];
      default:                            w_oe_want = 1'b0;
    endcase
    if (w_scl_rise) begin
      case (r_state)
        S_ADDR: begin
          w_addr_hit  = w_last_bit & w_addr_match;
          w_addr_miss = w_last_bit & ~w_addr_match;
        end
        S_ADDR_ACK:  w_rd_first = r_rw;
        S_PTR:       w_ptr_load = w_last_bit;
        S_WDATA:     w_commit   = w_last_bit;
        S_RDATA_ACK: w_rd_next  = ~w_sda_f;
        default:     ;
      endcase
    end
  end

  // wr_strobe is a single-cycle valid for wr_index/wr_data; there is no ready, the fabric must accept it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rw      <= 1'b0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_ptr     <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      wr_data   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (w_start) begin
        r_bit_cnt <= '0;
      end else if (w_scl_rise && (r_state == S_ADDR || r_state == S_PTR ||
                                  r_state == S_WDATA || r_state == S_RDATA)) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_shift   <= {r_shift[6:0], (r_state == S_RDATA) ? 1'b0 : w_sda_f};
      end
      if (w_addr_hit) begin
        busy <= 1'b1;
        r_rw <= w_sda_f;
      end
      if (w_addr_miss || w_stop) busy <= 1'b0;
      if (w_ptr_load) r_ptr <= w_ptr_mod;
      if (w_commit) begin
        r_regs[r_ptr] <= w_byte;
        wr_strobe     <= 1'b1;
        wr_index      <= r_ptr;
        wr_data       <= w_byte;
        r_ptr         <= w_ptr_inc;
      end
      if (w_rd_first) r_shift <= r_regs[r_ptr];
      if (w_rd_next) begin
        r_ptr   <= w_ptr_inc;
        r_shift <= r_regs[w_ptr_inc];
      end
      if (w_start || w_stop) sda_oe <= 1'b0;
      else if (w_hold_tick)  sda_oe <= w_oe_want;
    end
  end

  always_comb begin
    host_rdata = '0;
    if (int'(host_addr) < NUM_REGS) host_rdata = r_regs[host_addr];
  end

  assign scl_oe    = 1'b0;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged I2C master drives a table of bus operations,
// with hand-written sequences for glitch rejection, aborted bytes, wrong address and async reset.
module tb_i2c_target_regfile;

  localparam int Q = 20;
  localparam logic [1:0] OP_S = 2'd0, OP_P = 2'd1, OP_W = 2'd2, OP_R = 2'd3;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_PTR = 4'd3, ST_IGNORE = 4'd9;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic       mack;
    logic       exp_ack;
    logic [7:0] exp_rd;
    logic       exp_wr;
    logic [3:0] wr_idx;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       m_sda;
  logic       m_scl;
  logic       sda_oe;
  logic       scl_oe;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [3:0] wr_index;
  logic [7:0] wr_data;
  logic       busy;
  logic [3:0] dbg_state;
  logic       sda_line;
  logic       scl_line;

  int         checks;
  int         errors;
  vec_t       vt[48];
  int         nv;
  logic [11:0] exp_q[$];
  logic [7:0] exp_regs[16];
  logic [3:0] obs_idx[64];
  logic [7:0] obs_dat[64];
  int         obs_wr;
  int         obs_rd;
  int         oe_cnt;
  int         busy_cnt;

  assign sda_line = m_sda & ~sda_oe;
  assign scl_line = m_scl & ~scl_oe;

  i2c_target_regfile dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sda_in     (sda_line),
    .scl_in     (scl_line),
    .sda_oe     (sda_oe),
    .scl_oe     (scl_oe),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_strobe  (wr_strobe),
    .wr_index   (wr_index),
    .wr_data    (wr_data),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    obs_wr   = 0;
    oe_cnt   = 0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
      if (wr_strobe && obs_wr < 64) begin
        obs_idx[obs_wr] = wr_index;
        obs_dat[obs_wr] = wr_data;
        obs_wr++;
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic r);
    m_sda = b;
    wait_cyc(Q);
    m_scl = 1'b1;
    wait_cyc(Q);
    r = sda_line;
    wait_cyc(Q);
    m_scl = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_cyc(Q);
    m_scl = 1'b1;
    wait_cyc(Q);
    m_sda = 1'b0;
    wait_cyc(Q);
    m_scl = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_cyc(Q);
    m_scl = 1'b1;
    wait_cyc(Q);
    m_sda = 1'b1;
    wait_cyc(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
    clock_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      d[i] = r;
    end
    clock_bit(~mack, r);
  endtask

  task automatic expect_write(input logic [3:0] idx, input logic [7:0] d);
    exp_q.push_back({idx, d});
    exp_regs[idx] = d;
  endtask

  task automatic flush_writes();
    logic [11:0] e;
    chk("wr_count", obs_wr - obs_rd, exp_q.size());
    while (obs_rd < obs_wr && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_entry", {obs_idx[obs_rd], obs_dat[obs_rd]}, e);
      obs_rd++;
    end
    obs_rd = obs_wr;
    exp_q.delete();
  endtask

  task automatic add_vec(input logic [1:0] op, input logic [7:0] data, input logic mack,
                         input logic exp_ack, input logic [7:0] exp_rd,
                         input logic exp_wr, input logic [3:0] wr_idx);
    vt[nv] = '{op, data, mack, exp_ack, exp_rd, exp_wr, wr_idx};
    nv++;
  endtask

  task automatic apply_vec(input vec_t v);
    logic       ack;
    logic [7:0] d;
    case (v.op)
      OP_S: i2c_start();
      OP_P: begin
        i2c_stop();
        flush_writes();
      end
      OP_W: begin
        if (v.exp_wr) expect_write(v.wr_idx, v.data);
        write_byte(v.data, ack);
        chk($sformatf("ack_%02h", v.data), ack, v.exp_ack);
      end
      default: begin
        read_byte(v.mack, d);
        chk("rdata", d, v.exp_rd);
      end
    endcase
  endtask

  initial begin
    logic       r;
    logic       ack;
    logic [7:0] ptr_byte;
    int         oe0;
    int         busy0;
    vec_t       v;

    checks    = 0;
    errors    = 0;
    nv        = 0;
    obs_rd    = 0;
    m_sda     = 1'b1;
    m_scl     = 1'b1;
    host_addr = '0;
    reset_n   = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;

    // Transfers: write 03, setup 04/05, read back, burst wrap, read wrap, pointer modulo, read 07.
    add_vec(OP_S, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_W, 8'h54, 0, 1, 8'h00, 0, 0);
    add_vec(OP_W, 8'h03, 0, 1, 8'h00, 0, 0);
    add_vec(OP_W, 8'hA5, 0, 1, 8'h00, 1, 4'd3);
    add_vec(OP_P, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_S, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_W, 8'h54, 0, 1, 8'h00, 0, 0);
    add_vec(OP_W, 8'h04, 0, 1, 8'h00, 0, 0);
    add_vec(OP_W, 8'h3C, 0, 1, 8'h00, 1, 4'd4);
    add_vec(OP_W, 8'hC3, 0, 1, 8'h00, 1, 4'd5);
    add_vec(OP_P, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_S, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_W, 8'h54, 0, 1, 8'h00, 0, 0);
    add_vec(OP_W, 8'h03, 0, 1, 8'h00, 0, 0);
    add_vec(OP_S, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_W, 8'h55, 0, 1, 8'h00, 0, 0);
    add_vec(OP_R, 8'h00, 1, 0, 8'hA5, 0, 0);
    add_vec(OP_R, 8'h00, 1, 0, 8'h3C, 0, 0);
    add_vec(OP_R, 8'h00, 0, 0, 8'hC3, 0, 0);
    add_vec(OP_P, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_S, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_W, 8'h54, 0, 1, 8'h00, 0, 0);
    add_vec(OP_W, 8'h0F, 0, 1, 8'h00, 0, 0);
    add_vec(OP_W, 8'h11, 0, 1, 8'h00, 1, 4'd15);
    add_vec(OP_W, 8'h22, 0, 1, 8'h00, 1, 4'd0);
    add_vec(OP_P, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_S, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_W, 8'h54, 0, 1, 8'h00, 0, 0);
    add_vec(OP_W, 8'h0F, 0, 1, 8'h00, 0, 0);
    add_vec(OP_S, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_W, 8'h55, 0, 1, 8'h00, 0, 0);
    add_vec(OP_R, 8'h00, 1, 0, 8'h11, 0, 0);
    add_vec(OP_R, 8'h00, 0, 0, 8'h22, 0, 0);
    add_vec(OP_P, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_S, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_W, 8'h54, 0, 1, 8'h00, 0, 0);
    add_vec(OP_W, 8'h17, 0, 1, 8'h00, 0, 0);
    add_vec(OP_W, 8'h5A, 0, 1, 8'h00, 1, 4'd7);
    add_vec(OP_P, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_S, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_W, 8'h54, 0, 1, 8'h00, 0, 0);
    add_vec(OP_W, 8'h07, 0, 1, 8'h00, 0, 0);
    add_vec(OP_S, 8'h00, 0, 0, 8'h00, 0, 0);
    add_vec(OP_W, 8'h55, 0, 1, 8'h00, 0, 0);
    add_vec(OP_R, 8'h00, 0, 0, 8'h5A, 0, 0);
    add_vec(OP_P, 8'h00, 0, 0, 8'h00, 0, 0);

    wait_cyc(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_rdata", host_rdata, 0);
    reset_n = 1'b1;
    wait_cyc(20);

    // Two-cycle SDA dip with SCL high while idle must not look like a START.
    m_sda = 1'b0;
    wait_cyc(2);
    m_sda = 1'b1;
    wait_cyc(20);
    chk("glitch_idle_state", dbg_state, ST_IDLE);

    for (int i = 0; i < nv; i++) apply_vec(vt[i]);

    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i);
      wait_cyc(1);
      chk($sformatf("regs_%0d", i), host_rdata, exp_regs[i]);
    end

    // Wrong address: never ACKed, never busy, write byte ignored.
    oe0   = oe_cnt;
    busy0 = busy_cnt;
    i2c_start();
    write_byte(8'h56, ack);
    chk("wrong_addr_ack", ack, 0);
    chk("wrong_addr_state", dbg_state, ST_IGNORE);
    write_byte(8'h01, ack);
    chk("wrong_data_ack", ack, 0);
    i2c_stop();
    chk("wrong_oe_cycles", oe_cnt - oe0, 0);
    chk("wrong_busy_cycles", busy_cnt - busy0, 0);
    flush_writes();

    // STOP after four data bits: byte dropped, then a normal write to the same register.
    i2c_start();
    write_byte(8'h54, ack);
    chk("part_addr_ack", ack, 1);
    chk("part_busy", busy, 1);
    write_byte(8'h02, ack);
    chk("part_ptr_ack", ack, 1);
    clock_bit(1'b1, r);
    clock_bit(1'b0, r);
    clock_bit(1'b1, r);
    clock_bit(1'b1, r);
    i2c_stop();
    chk("part_state", dbg_state, ST_IDLE);
    chk("part_busy_clr", busy, 0);
    flush_writes();
    host_addr = 4'd2;
    wait_cyc(1);
    chk("part_reg2", host_rdata, exp_regs[2]);
    apply_vec('{OP_S, 8'h00, 0, 0, 8'h00, 0, 0});
    apply_vec('{OP_W, 8'h54, 0, 1, 8'h00, 0, 0});
    apply_vec('{OP_W, 8'h02, 0, 1, 8'h00, 0, 0});
    apply_vec('{OP_W, 8'h77, 0, 1, 8'h00, 1, 4'd2});
    apply_vec('{OP_P, 8'h00, 0, 0, 8'h00, 0, 0});
    wait_cyc(1);
    chk("after_part_reg2", host_rdata, 8'h77);

    // SDA glitch while SCL is high inside the pointer byte must not restart or stop the transfer.
    i2c_start();
    write_byte(8'h54, ack);
    chk("glitch_addr_ack", ack, 1);
    ptr_byte = 8'h81;
    m_sda = 1'b1;
    wait_cyc(Q);
    m_scl = 1'b1;
    wait_cyc(Q);
    m_sda = 1'b0;
    wait_cyc(2);
    m_sda = 1'b1;
    wait_cyc(Q);
    m_scl = 1'b0;
    wait_cyc(Q);
    chk("glitch_state", dbg_state, ST_PTR);
    chk("glitch_busy", busy, 1);
    for (int i = 6; i >= 0; i--) clock_bit(ptr_byte[i], r);
    clock_bit(1'b1, r);
    chk("glitch_ptr_ack", r, 0);
    v = '{OP_W, 8'h99, 0, 1, 8'h00, 1, 4'd1};
    apply_vec(v);
    apply_vec('{OP_P, 8'h00, 0, 0, 8'h00, 0, 0});
    host_addr = 4'd1;
    wait_cyc(1);
    chk("glitch_reg1", host_rdata, 8'h99);

    // Async reset while the target drives a 0 data bit of a read.
    apply_vec('{OP_S, 8'h00, 0, 0, 8'h00, 0, 0});
    apply_vec('{OP_W, 8'h54, 0, 1, 8'h00, 0, 0});
    apply_vec('{OP_W, 8'h03, 0, 1, 8'h00, 0, 0});
    apply_vec('{OP_S, 8'h00, 0, 0, 8'h00, 0, 0});
    apply_vec('{OP_W, 8'h55, 0, 1, 8'h00, 0, 0});
    clock_bit(1'b1, r);
    chk("rd_bit7", r, 1);
    m_sda = 1'b1;
    wait_cyc(Q);
    m_scl = 1'b1;
    wait_cyc(10);
    chk("rd_bit6_drive", sda_oe, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_oe", sda_oe, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_state", dbg_state, ST_IDLE);
    wait_cyc(3);
    m_scl     = 1'b1;
    m_sda     = 1'b1;
    reset_n   = 1'b1;
    host_addr = 4'd3;
    wait_cyc(20);
    chk("post_rst_reg3", host_rdata, 0);
    flush_writes();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
